// File: rtl/pipe_ctrl.sv
// Pipeline hazard/stall controller: load-use interlock, branch flush, memory-wait FSM with timeout.
// Optional performance counters built when PIPE_PERF_CNT_EN is defined.
module pipe_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  input  logic        id_use_rs1,
  input  logic        id_use_rs2,
  input  logic [4:0]  ex_rd,
  input  logic        ex_mem_read,
  input  logic        branch_taken,
  input  logic        mem_req,
  input  logic        mem_ready,
  output logic        pc_en,
  output logic        if_id_en,
  output logic        id_ex_en,
  output logic        ex_mem_en,
  output logic        mem_wb_en,
  output logic        if_id_flush,
  output logic        id_ex_flush,
  output logic        mem_err,
  output logic [31:0] stall_cnt_mem,
  output logic [31:0] stall_cnt_lu,
  output logic [31:0] flush_cnt
);

  typedef enum logic {RUN, MEM_WAIT} state_t;

  localparam logic [7:0] TIMEOUT = 8'(MEM_TIMEOUT);

  state_t     state;
  logic [7:0] wait_cnt;
  logic       mem_stall;
  logic       load_use;

  assign mem_stall = mem_req & ~mem_ready;
  assign load_use  = ex_mem_read & (ex_rd != 5'd0) &
                     ((id_use_rs1 & (id_rs1 == ex_rd)) | (id_use_rs2 & (id_rs2 == ex_rd)));

  always_comb begin
    pc_en       = 1'b0;
    if_id_en    = 1'b0;
    id_ex_en    = 1'b0;
    ex_mem_en   = 1'b0;
    mem_wb_en   = 1'b0;
    if_id_flush = 1'b0;
    id_ex_flush = 1'b0;
    if (enable && !mem_stall) begin
      id_ex_en  = 1'b1;
      ex_mem_en = 1'b1;
      mem_wb_en = 1'b1;
      if (branch_taken) begin
        pc_en       = 1'b1;
        if_id_en    = 1'b1;
        if_id_flush = 1'b1;
        id_ex_flush = 1'b1;
      end else if (load_use) begin
        id_ex_flush = 1'b1;
      end else begin
        pc_en    = 1'b1;
        if_id_en = 1'b1;
      end
    end
  end

  // A dropped mem_req in MEM_WAIT is not a stall, so it falls into the return-to-RUN path.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= RUN;
      wait_cnt <= '0;
      mem_err  <= 1'b0;
    end else if (enable) begin
      case (state)
        RUN: begin
          if (mem_stall) begin
            state    <= MEM_WAIT;
            wait_cnt <= 8'd1;
          end
        end
        MEM_WAIT: begin
          if (mem_stall) begin
            if (wait_cnt != 8'hFF) wait_cnt <= wait_cnt + 8'd1;
            if (wait_cnt >= TIMEOUT) mem_err <= 1'b1;
          end else begin
            state    <= RUN;
            wait_cnt <= '0;
          end
        end
        default: begin
          state    <= RUN;
          wait_cnt <= '0;
        end
      endcase
    end
  end

`ifdef PIPE_PERF_CNT_EN
  logic lu_cycle;
  logic br_cycle;

  assign br_cycle = ~mem_stall & branch_taken;
  assign lu_cycle = ~mem_stall & ~branch_taken & load_use;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_mem <= '0;
      stall_cnt_lu  <= '0;
      flush_cnt     <= '0;
    end else if (enable) begin
      if (mem_stall) stall_cnt_mem <= stall_cnt_mem + 32'd1;
      if (lu_cycle)  stall_cnt_lu  <= stall_cnt_lu + 32'd1;
      if (br_cycle)  flush_cnt     <= flush_cnt + 32'd1;
    end
  end
`else
  assign stall_cnt_mem = '0;
  assign stall_cnt_lu  = '0;
  assign flush_cnt     = '0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed scoreboard bench for pipe_ctrl: driver pushes hand-computed expectations, monitor checks at negedge.
module tb_pipe_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b1;
  logic [4:0]  id_rs1 = '0, id_rs2 = '0, ex_rd = '0;
  logic        id_use_rs1 = 1'b0, id_use_rs2 = 1'b0;
  logic        ex_mem_read = 1'b0, branch_taken = 1'b0;
  logic        mem_req = 1'b0, mem_ready = 1'b0;
  logic        pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
  logic        if_id_flush, id_ex_flush, mem_err;
  logic [31:0] stall_cnt_mem, stall_cnt_lu, flush_cnt;

  pipe_ctrl #(.MEM_TIMEOUT(4)) dut (
    .clk(clk), .rst(rst), .enable(enable),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .ex_rd(ex_rd), .ex_mem_read(ex_mem_read), .branch_taken(branch_taken),
    .mem_req(mem_req), .mem_ready(mem_ready),
    .pc_en(pc_en), .if_id_en(if_id_en), .id_ex_en(id_ex_en), .ex_mem_en(ex_mem_en),
    .mem_wb_en(mem_wb_en), .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
    .mem_err(mem_err), .stall_cnt_mem(stall_cnt_mem), .stall_cnt_lu(stall_cnt_lu),
    .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  // ctl = {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en, if_id_flush, id_ex_flush}
  localparam logic [6:0] NORM = 7'b1111100;
  localparam logic [6:0] LU   = 7'b0011101;
  localparam logic [6:0] BR   = 7'b1111111;
  localparam logic [6:0] HOLD = 7'b0000000;

  typedef struct {
    string       name;
    logic [6:0]  ctl;
    logic        err;
    logic [31:0] c_mem;
    logic [31:0] c_lu;
    logic [31:0] c_fl;
  } exp_t;

  exp_t q[$];
  int n_cmp = 0;
  int n_bad = 0;
  int m_mem = 0, m_lu = 0, m_fl = 0;

  task automatic chk(input string nm, input string fld, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s.%s actual=%0h required=%0h", nm, fld, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (q.size() != 0) begin
      exp_t e;
      e = q.pop_front();
      chk(e.name, "ctl", {25'd0, pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en, if_id_flush, id_ex_flush},
          {25'd0, e.ctl});
      chk(e.name, "mem_err", {31'd0, mem_err}, {31'd0, e.err});
      chk(e.name, "stall_cnt_mem", stall_cnt_mem, e.c_mem);
      chk(e.name, "stall_cnt_lu", stall_cnt_lu, e.c_lu);
      chk(e.name, "flush_cnt", flush_cnt, e.c_fl);
    end
  end

  // One cycle of stimulus; rpulse fires an async reset between edges before the expectation is taken.
  task automatic step(input string nm, input logic en, input logic [4:0] rs1, input logic [4:0] rs2,
                      input logic u1, input logic u2, input logic [4:0] rd, input logic mr,
                      input logic br, input logic mreq, input logic mrdy,
                      input logic [6:0] ctl, input logic err, input logic rpulse);
    exp_t e;
    @(posedge clk);
    #1;
    rst = 1'b0;
    enable = en; id_rs1 = rs1; id_rs2 = rs2; id_use_rs1 = u1; id_use_rs2 = u2;
    ex_rd = rd; ex_mem_read = mr; branch_taken = br; mem_req = mreq; mem_ready = mrdy;
    if (rpulse) begin
      #1 rst = 1'b1;
      #1 rst = 1'b0;
      m_mem = 0; m_lu = 0; m_fl = 0;
    end
    e.name = nm; e.ctl = ctl; e.err = err;
`ifdef PIPE_PERF_CNT_EN
    e.c_mem = m_mem; e.c_lu = m_lu; e.c_fl = m_fl;
`else
    e.c_mem = 0; e.c_lu = 0; e.c_fl = 0;
`endif
    q.push_back(e);
    if (en) begin
      if (ctl == HOLD) m_mem++;
      else if (ctl == LU) m_lu++;
      else if (ctl == BR) m_fl++;
    end
  endtask

  initial begin
    int guard;
    // held in reset at first check: outputs follow inputs, state cleared
    @(negedge clk);
    q.push_back('{"reset", NORM, 1'b0, 0, 0, 0});
    step("normal",   1, 0, 0, 0, 0, 0, 0, 0, 0, 0, NORM, 0, 0);
    step("lu_rs1",   1, 5, 0, 1, 0, 5, 1, 0, 0, 0, LU,   0, 0);
    step("lu_gone",  1, 0, 0, 0, 0, 0, 0, 0, 0, 0, NORM, 0, 0);
    step("lu_rd0",   1, 0, 0, 1, 0, 0, 1, 0, 0, 0, NORM, 0, 0);
    step("lu_rs2",   1, 1, 7, 0, 1, 7, 1, 0, 0, 0, LU,   0, 0);
    step("rs2_nouse",1, 1, 7, 0, 0, 7, 1, 0, 0, 0, NORM, 0, 0);
    step("lu_br",    1, 5, 0, 1, 0, 5, 1, 1, 0, 0, BR,   0, 0);
    step("br_only",  1, 0, 0, 0, 0, 0, 0, 1, 0, 0, BR,   0, 0);
    step("lu_n1",    1, 9, 0, 1, 0, 9, 1, 0, 0, 0, LU,   0, 0);
    step("lu_n2",    1, 9, 0, 1, 0, 9, 1, 0, 0, 0, LU,   0, 0);
    step("lu_end",   1, 0, 0, 0, 0, 0, 0, 0, 0, 0, NORM, 0, 0);
    step("dis_lu",   0, 9, 0, 1, 0, 9, 1, 0, 0, 0, HOLD, 0, 0);
    step("mstall1",  1, 0, 0, 0, 0, 0, 0, 0, 1, 0, HOLD, 0, 0);
    step("mstall2",  1, 0, 0, 0, 0, 0, 0, 0, 1, 0, HOLD, 0, 0);
    step("mstall3",  1, 0, 0, 0, 0, 0, 0, 0, 1, 0, HOLD, 0, 0);
    step("mready",   1, 0, 0, 0, 0, 0, 0, 0, 1, 1, NORM, 0, 0);
    step("stall_br", 1, 0, 0, 0, 0, 0, 0, 1, 1, 0, HOLD, 0, 0);
    step("req_drop", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, NORM, 0, 0);
    // timeout 4: err sets on the 5th enabled stall edge; disabled cycles must not advance it
    step("to_a",     1, 0, 0, 0, 0, 0, 0, 0, 1, 0, HOLD, 0, 0);
    for (int i = 0; i < 5; i++)
      step("to_frz", 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, HOLD, 0, 0);
    step("to_b",     1, 0, 0, 0, 0, 0, 0, 0, 1, 0, HOLD, 0, 0);
    step("to_c",     1, 0, 0, 0, 0, 0, 0, 0, 1, 0, HOLD, 0, 0);
    step("to_d",     1, 0, 0, 0, 0, 0, 0, 0, 1, 0, HOLD, 0, 0);
    step("to_e",     1, 0, 0, 0, 0, 0, 0, 0, 1, 0, HOLD, 0, 0);
    step("to_f",     1, 0, 0, 0, 0, 0, 0, 0, 1, 0, HOLD, 1, 0);
    step("to_ready", 1, 0, 0, 0, 0, 0, 0, 0, 1, 1, NORM, 1, 0);
    step("to_norm",  1, 0, 0, 0, 0, 0, 0, 0, 0, 0, NORM, 1, 0);
    step("w_start",  1, 0, 0, 0, 0, 0, 0, 0, 1, 0, HOLD, 1, 0);
    step("rst_mid",  1, 0, 0, 0, 0, 0, 0, 0, 1, 0, HOLD, 0, 1);
    step("post_r2",  1, 0, 0, 0, 0, 0, 0, 0, 1, 0, HOLD, 0, 0);
    step("post_r3",  1, 0, 0, 0, 0, 0, 0, 0, 1, 0, HOLD, 0, 0);
    step("post_r4",  1, 0, 0, 0, 0, 0, 0, 0, 1, 0, HOLD, 0, 0);
    step("post_rdy", 1, 0, 0, 0, 0, 0, 0, 0, 1, 1, NORM, 0, 0);
    step("post_lu",  1, 3, 0, 1, 0, 3, 1, 0, 0, 0, LU,   0, 0);
    step("post_br",  1, 0, 0, 0, 0, 0, 0, 1, 0, 0, BR,   0, 0);
    step("final",    1, 0, 0, 0, 0, 0, 0, 0, 0, 0, NORM, 0, 0);
    guard = 0;
    while (q.size() != 0 && guard < 20) begin
      @(posedge clk);
      guard++;
    end
    if (q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain pending=%0d required=0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 Parameter MEM_TIMEOUT, 16, MEM_WAIT cycles (1..255) before mem_err sets.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst  in  1  asynchronous, active-high reset.
REQ-004 enable  in  1  global run; 0 freezes pipeline and FSM.
REQ-005 id_rs1, id_rs2  in  5 each  source registers of instruction in ID.
REQ-006 id_use_rs1, id_use_rs2  in  1 each  ID instruction reads rs1/rs2.
REQ-007 ex_rd  in  5  destination register of instruction in EX.
REQ-008 ex_mem_read  in  1  EX instruction is a load.
REQ-009 branch_taken  in  1  EX resolved taken branch/jump.
REQ-010 mem_req, mem_ready  in  1 each  MEM-stage data-memory request / acknowledge.
REQ-011 pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en  out  1 each  stage register enables.
REQ-012 if_id_flush, id_ex_flush  out  1 each  synchronous bubble insert into IF/ID, ID/EX.
REQ-013 mem_err  out  1  sticky memory-timeout flag.
REQ-014 stall_cnt_mem, stall_cnt_lu, flush_cnt  out  32 each  performance counters.

Function
REQ-015 FSM states RUN, MEM_WAIT; enables/flushes combinational from state and inputs.
REQ-016 mem_stall = mem_req & ~mem_ready, in either state.
REQ-017 load_use = ex_mem_read & ex_rd!=0 & ((id_use_rs1 & id_rs1==ex_rd) | (id_use_rs2 & id_rs2==ex_rd)).
REQ-018 Priority: enable=0 > mem_stall > branch_taken > load_use > normal.
REQ-019 enable=0: all enables 0, flushes 0, state, counters and mem_err hold.
REQ-020 mem_stall: all five enables 0, flushes 0.
REQ-021 branch_taken (no mem_stall): all enables 1, if_id_flush=1, id_ex_flush=1; load_use ignored.
REQ-022 load_use (no mem_stall, no branch): pc_en=0, if_id_en=0, id_ex_flush=1, id_ex_en/ex_mem_en/mem_wb_en=1.
REQ-023 Normal: all enables 1, flushes 0.
REQ-024 RUN->MEM_WAIT on mem_stall, wait_cnt<=1; MEM_WAIT->RUN in cycle mem_ready=1 (pipeline advances that cycle), wait_cnt<=0.
REQ-025 MEM_WAIT with mem_stall: wait_cnt 8-bit increments, saturates at 255.
REQ-026 mem_err sets when state=MEM_WAIT, mem_stall=1, wait_cnt>=MEM_TIMEOUT; clears only on rst; pipeline stays stalled.
REQ-027 mem_req falling to 0 in MEM_WAIT treated as ready: return to RUN.
REQ-028 A one-cycle hazard holding for N cycles stalls exactly N cycles; no extra bubbles.

Reset
REQ-029 rst asserted: state=RUN, wait_cnt=0, mem_err=0, all counters 0, immediately and independent of clk.
REQ-030 During rst enables and flushes follow REQ-015..023 from inputs; rst mid-MEM_WAIT aborts the wait with no error.

Configuration
REQ-031 PIPE_PERF_CNT_EN defined: stall_cnt_mem +1 per mem_stall cycle, stall_cnt_lu +1 per REQ-022 cycle, flush_cnt +1 per REQ-021 cycle; only when enable=1; 32-bit wrap-around.
REQ-032 PIPE_PERF_CNT_EN undefined: counters not built, three outputs tied 0; all other behaviour identical.

Verification
REQ-033 ex_mem_read=1, ex_rd=5, id_rs1=5, id_use_rs1=1 for 1 cycle -> pc_en=0, if_id_en=0, id_ex_flush=1 that cycle only.
REQ-034 Same as REQ-033 but ex_rd=0 -> no stall, all enables 1.
REQ-035 load_use and branch_taken together -> if_id_flush=id_ex_flush=1, pc_en=1.
REQ-036 mem_req=1, mem_ready=0 for 3 cycles then 1 -> enables 0 for 3 cycles, state MEM_WAIT, RUN after ready cycle; stall_cnt_mem=3.
REQ-037 MEM_TIMEOUT=4, mem_ready held 0 -> mem_err=1 after 5th stall cycle edge, stays 1 after ready; cleared only by rst.
REQ-038 rst pulse mid-MEM_WAIT between edges -> state RUN, wait_cnt/mem_err/counters 0 immediately.
